// File: rtl/demux_8_buf.sv
// demux_8_buf: registered 1-to-8 dispatcher.
// One word per cycle enters on a valid/ready port and is steered by in_select
// into one of eight single-entry holding registers, each with its own
// valid/ready output handshake. A channel can be refilled in the same cycle it
// drains, so a single channel streams at full rate.
// Optional feature: define DEMUX8_BROADCAST_EN to add the in_bcast input, which
// loads one word into all eight channels at once (all-or-nothing).
module demux_8_buf #(
  parameter int WIDTH = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_select,
  input  logic [WIDTH-1:0]   in_data,
`ifdef DEMUX8_BROADCAST_EN
  input  logic               in_bcast,
`endif
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [7:0]         drop_count
);

  // Channel state: occupancy flag and held word per channel.
  logic [7:0]       full;
  logic [WIDTH-1:0] hold [8];

  // Per-channel handshake terms.
  logic [7:0] can;     // channel k can take a word this cycle
  logic [7:0] drain;   // sink k consumes its held word this cycle
  logic [7:0] load;    // channel k is written this cycle
  logic       accept;  // input handshake completes
  logic       stall;   // source waits on a busy destination

  // A channel is free if empty, or if its current word leaves this cycle.
  assign can    = ~full | out_ready;
  assign drain  = full & out_ready;
  assign accept = in_valid & in_ready;
  assign stall  = in_valid & ~in_ready;

  // Input readiness and per-channel load enables.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    in_ready = can[in_select];
    load     = '0;
`ifdef DEMUX8_BROADCAST_EN
    if (in_bcast) begin
      // Broadcast is all-or-nothing: every channel must be free together.
      in_ready = &can;
      load     = {8{accept}};
    end else begin
      load[in_select] = accept;
    end
`else
    load[in_select] = accept;
`endif
  end

  // Channel registers: load wins over drain, so a word drained this cycle is
  // replaced without a bubble.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      full <= '0;
      // NOTE: the holding registers are cleared on reset because out_data is
      // defined as zero after reset; a plain storage array would not need it.
      for (int k = 0; k < 8; k++) begin
        hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (load[k]) begin
          hold[k] <= in_data;
          full[k] <= 1'b1;
        end else if (drain[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating stall counter for debug visibility.
  always_ff @(posedge clock) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (stall && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Pack channel state onto the output ports.
  always_comb begin
    out_valid = full;
    out_data  = '0;
    for (int k = 0; k < 8; k++) begin
      out_data[k*WIDTH +: WIDTH] = hold[k];
    end
  end

endmodule

// File: tb/tb_demux_8_buf.sv
// tb_demux_8_buf: directed self-checking bench for demux_8_buf (WIDTH=8).
// Exercises the DEMUX8_BROADCAST_EN feature when that macro is defined.
module tb_demux_8_buf;

  localparam int WIDTH = 8;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_select;
  logic [WIDTH-1:0]   in_data;
`ifdef DEMUX8_BROADCAST_EN
  logic               in_bcast;
`endif
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [7:0]         drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx [$];

  demux_8_buf #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
`ifdef DEMUX8_BROADCAST_EN
    .in_bcast   (in_bcast),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] slice(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    // Reset with random inputs for two edges.
    reset     = 1'b0;
    in_valid  = 1'($urandom);
    in_select = 3'($urandom);
    in_data   = 8'($urandom);
    out_ready = 8'($urandom);
`ifdef DEMUX8_BROADCAST_EN
    in_bcast  = 1'b0;
`endif
    tick();
    in_valid  = 1'($urandom);
    in_select = 3'($urandom);
    in_data   = 8'($urandom);
    out_ready = 8'($urandom);
    tick();
    check("rst_valid", 64'(out_valid), 64'h00);
    check("rst_data", out_data, 64'h0);
    check("rst_drop", 64'(drop_count), 64'h00);

    // First word into channel 3.
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_select = 3'd3;
    in_data   = 8'hA5;
    out_ready = 8'h00;
    #1;
    check("first_ready", 64'(in_ready), 64'h1);
    tick();
    check("first_valid", 64'(out_valid), 64'h08);
    check("first_slice3", 64'(slice(3)), 64'hA5);
    check("first_drop", 64'(drop_count), 64'h00);

    // Backpressure: channel 3 stalled for five cycles.
    in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 64'(in_ready), 64'h0);
      tick();
      check("bp_slice3", 64'(slice(3)), 64'hA5);
    end
    check("bp_drop", 64'(drop_count), 64'h05);

    // Another channel proceeds while channel 3 is stalled.
    in_select = 3'd6;
    in_data   = 8'h66;
    #1;
    check("ch6_ready", 64'(in_ready), 64'h1);
    tick();
    check("ch6_valid", 64'(out_valid), 64'h48);
    check("ch6_slice", 64'(slice(6)), 64'h66);
    check("ch6_drop", 64'(drop_count), 64'h05);

    // Fill channel 2 with 8'h11, then drain and reload it in one cycle.
    in_select = 3'd2;
    in_data   = 8'h11;
    tick();
    check("ch2_fill", 64'(out_valid), 64'h4C);
    out_ready = 8'h04;
    in_data   = 8'h22;
    #1;
    check("dl_ready", 64'(in_ready), 64'h1);
    tick();
    check("dl_valid2", 64'(out_valid[2]), 64'h1);
    check("dl_slice2", 64'(slice(2)), 64'h22);

    // Streaming burst 0..15 through channel 2, sink always ready.
    rx.delete();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      #1;
      check("burst_ready", 64'(in_ready), 64'h1);
      check("burst_valid", 64'(out_valid[2]), 64'h1);
      if (out_valid[2] && out_ready[2]) rx.push_back(slice(2));
      tick();
    end
    in_valid = 1'b0;
    #1;
    if (out_valid[2] && out_ready[2]) rx.push_back(slice(2));
    tick();
    check("burst_count", 64'(rx.size()), 64'd17);
    if (rx.size() == 17) begin
      check("burst_old", 64'(rx[0]), 64'h22);
      for (int i = 0; i < 16; i++) check("burst_word", 64'(rx[i+1]), 64'(i));
    end
    check("burst_empty", 64'(out_valid), 64'h48);
    out_ready = 8'h00;

    // Saturation: blocked channel 3 for 300 cycles, starting from 5.
    in_valid  = 1'b1;
    in_select = 3'd3;
    for (int i = 0; i < 249; i++) tick();
    check("sat_fe", 64'(drop_count), 64'hFE);
    tick();
    check("sat_ff", 64'(drop_count), 64'hFF);
    for (int i = 0; i < 50; i++) tick();
    check("sat_hold", 64'(drop_count), 64'hFF);
    check("sat_slice3", 64'(slice(3)), 64'hA5);

    // Drain channels 3 and 6, then fill 0, 5, 7.
    in_valid  = 1'b0;
    out_ready = 8'h48;
    tick();
    check("drain36", 64'(out_valid), 64'h00);
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_select = 3'd0; in_data = 8'h10; tick();
    in_select = 3'd5; in_data = 8'h50; tick();
    in_select = 3'd7; in_data = 8'h70; tick();
    check("fill057", 64'(out_valid), 64'hA1);
    check("fill_slice5", 64'(slice(5)), 64'h50);

    // Mid-operation reset with sinks and source all active.
    reset     = 1'b0;
    out_ready = 8'hA1;
    in_select = 3'd1;
    in_data   = 8'hEE;
    tick();
    check("mrst_valid", 64'(out_valid), 64'h00);
    check("mrst_data", out_data, 64'h0);
    check("mrst_drop", 64'(drop_count), 64'h00);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 8'h00;
    #1;
    check("mrst_ready", 64'(in_ready), 64'h1);
    tick();
    check("mrst_idle", 64'(out_valid), 64'h00);

`ifdef DEMUX8_BROADCAST_EN
    // Broadcast blocked by stalled channel 4, then released.
    in_valid  = 1'b1;
    in_select = 3'd4;
    in_data   = 8'h44;
    tick();
    check("bc_fill4", 64'(out_valid), 64'h10);
    in_bcast  = 1'b1;
    in_select = 3'd1;
    in_data   = 8'h3C;
    #1;
    check("bc_blocked", 64'(in_ready), 64'h0);
    tick();
    check("bc_nochange", 64'(out_valid), 64'h10);
    check("bc_slice4", 64'(slice(4)), 64'h44);
    out_ready = 8'h10;
    #1;
    check("bc_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 8'h00;
    check("bc_valid", 64'(out_valid), 64'hFF);
    check("bc_data", out_data, {8{8'h3C}});
    check("bc_drop", 64'(drop_count), 64'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
